// File: rtl/mem_stage_access_unit.sv
// MEM pipeline stage: scalar and two-beat vector loads/stores over a 32-bit req/ack
// data-memory port, producing the MEM/WB register contents and the upstream stall.
module mem_stage_access_unit #(
   parameter int ADDR_W = 32,
   parameter int VEC_W  = 48
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write,
   input  logic              vreg_write,
   input  logic              vec_op,
   input  logic              mem_write,
   input  logic [1:0]        mem_to_reg,
   input  logic [31:0]       pc_count,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       rd2,
   input  logic [31:0]       sign_imm,
   input  logic [4:0]        rd,
   input  logic [4:0]        vd,
   input  logic [VEC_W-1:0]  alu_result_v,
   input  logic [VEC_W-1:0]  rd2_v,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   output logic [3:0]        dm_be,
   input  logic [31:0]       dm_rdata,
   input  logic              dm_ack,
   output logic              stall,
   output logic              misalign,
   output logic              wb_reg_write,
   output logic              wb_vreg_write,
   output logic [4:0]        wb_rd,
   output logic [4:0]        wb_vd,
   output logic [31:0]       wb_data,
   output logic [VEC_W-1:0]  wb_data_v
);

   typedef enum logic {IDLE, BEAT1} state_t;

   state_t      state;
   logic [31:0] low_buf;
   logic        mem_op;
   logic        is_load;
   logic [ADDR_W-1:0] base_addr;
   logic [31:0] sel_data;

   assign mem_op    = mem_write || (mem_to_reg == 2'b01);
   assign is_load   = (mem_to_reg == 2'b01);
   assign base_addr = {alu_result[ADDR_W-1:2], 2'b00};
   assign dm_we     = mem_write;

   always_comb begin
      case (mem_to_reg)
         2'b01:   sel_data = dm_rdata;
         2'b10:   sel_data = pc_count + 32'd4;
         2'b11:   sel_data = sign_imm;
         default: sel_data = alu_result;
      endcase
   end

   // Address/data are pure functions of frozen EX/MEM fields and state, so they hold during waits.
   always_comb begin
      dm_addr  = base_addr;
      dm_wdata = vec_op ? rd2_v[31:0] : rd2;
      dm_be    = 4'b1111;
      if (state == BEAT1) begin
         dm_addr  = base_addr + {{(ADDR_W-3){1'b0}}, 3'b100};
         dm_wdata = {16'b0, rd2_v[VEC_W-1:32]};
         dm_be    = 4'b0011;
      end
   end

   always_comb begin
      dm_req = 1'b0;
      stall  = 1'b0;
      if (!rst) begin
         if (state == BEAT1) begin
            dm_req = 1'b1;
            stall  = !dm_ack;
         end else if (mem_op) begin
            dm_req = 1'b1;
            stall  = !(dm_ack && !vec_op);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         low_buf       <= '0;
         misalign      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_vreg_write <= 1'b0;
         wb_rd         <= '0;
         wb_vd         <= '0;
         wb_data       <= '0;
         wb_data_v     <= '0;
      end else begin
         misalign      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_vreg_write <= 1'b0;
         case (state)
            IDLE: begin
               if (!mem_op) begin
                  wb_reg_write  <= reg_write;
                  wb_vreg_write <= vreg_write;
                  wb_rd         <= rd;
                  wb_vd         <= vd;
                  wb_data       <= sel_data;
                  wb_data_v     <= alu_result_v;
               end else if (dm_ack) begin
                  misalign <= (alu_result[1:0] != 2'b00);
                  if (vec_op) begin
                     low_buf <= dm_rdata;
                     state   <= BEAT1;
                  end else begin
                     wb_reg_write  <= reg_write && !mem_write;
                     wb_vreg_write <= vreg_write && !mem_write;
                     wb_rd         <= rd;
                     wb_vd         <= vd;
                     wb_data       <= sel_data;
                     wb_data_v     <= alu_result_v;
                  end
               end
            end
            BEAT1: begin
               if (dm_ack) begin
                  state         <= IDLE;
                  low_buf       <= '0;
                  wb_reg_write  <= reg_write && !mem_write;
                  wb_vreg_write <= vreg_write && !mem_write;
                  wb_rd         <= rd;
                  wb_vd         <= vd;
                  wb_data       <= sel_data;
                  wb_data_v     <= is_load ? {dm_rdata[15:0], low_buf} : alu_result_v;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit: hand-computed expectations checked
// with immediate assertions.
module tb_mem_stage_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_write, vreg_write, vec_op, mem_write;
   logic [1:0]  mem_to_reg;
   logic [31:0] pc_count, alu_result, rd2, sign_imm;
   logic [4:0]  rd, vd;
   logic [47:0] alu_result_v, rd2_v;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        stall, misalign;
   logic        wb_reg_write, wb_vreg_write;
   logic [4:0]  wb_rd, wb_vd;
   logic [31:0] wb_data;
   logic [47:0] wb_data_v;

   int n_tests = 0;
   int n_fail  = 0;

   mem_stage_access_unit #(.ADDR_W(32), .VEC_W(48)) dut (
      .clk(clk), .rst(rst),
      .reg_write(reg_write), .vreg_write(vreg_write), .vec_op(vec_op),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .pc_count(pc_count),
      .alu_result(alu_result), .rd2(rd2), .sign_imm(sign_imm), .rd(rd), .vd(vd),
      .alu_result_v(alu_result_v), .rd2_v(rd2_v),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .stall(stall), .misalign(misalign),
      .wb_reg_write(wb_reg_write), .wb_vreg_write(wb_vreg_write),
      .wb_rd(wb_rd), .wb_vd(wb_vd), .wb_data(wb_data), .wb_data_v(wb_data_v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      reg_write = 0; vreg_write = 0; vec_op = 0; mem_write = 0; mem_to_reg = 2'b00;
      pc_count = 0; alu_result = 0; rd2 = 0; sign_imm = 0; rd = 0; vd = 0;
      alu_result_v = 0; rd2_v = 0; dm_rdata = 0; dm_ack = 0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      chk("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
      chk("rst_wb_data", 64'(wb_data), 64'd0);
      chk("rst_wb_data_v", 64'(wb_data_v), 64'd0);
      chk("rst_misalign", 64'(misalign), 64'd0);
      chk("rst_dm_req", 64'(dm_req), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      rst = 1'b0;
      tick();

      // Non-memory op: pc_count + 4 writeback
      mem_to_reg = 2'b10; pc_count = 32'h100; rd = 5; reg_write = 1;
      alu_result_v = 48'h1111_22223333; dm_ack = 1;
      #1;
      chk("nm_stall", 64'(stall), 64'd0);
      chk("nm_dm_req", 64'(dm_req), 64'd0);
      tick();
      chk("nm_wb_data", 64'(wb_data), 64'h104);
      chk("nm_wb_rd", 64'(wb_rd), 64'd5);
      chk("nm_wb_reg_write", 64'(wb_reg_write), 64'd1);
      chk("nm_wb_data_v", 64'(wb_data_v), 64'h1111_22223333);
      clear_inputs();

      // Scalar load, ack after 3 waiting cycles
      mem_to_reg = 2'b01; reg_write = 1; rd = 7; alu_result = 32'h2000;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sl_wait_stall", 64'(stall), 64'd1);
         chk("sl_wait_addr", 64'(dm_addr), 64'h2000);
         chk("sl_wait_req_we", {62'd0, dm_req, dm_we}, 64'b10);
         tick();
         chk("sl_bubble", 64'(wb_reg_write), 64'd0);
      end
      dm_ack = 1; dm_rdata = 32'hDEADBEEF;
      #1;
      chk("sl_ack_stall", 64'(stall), 64'd0);
      tick();
      chk("sl_wb_data", 64'(wb_data), 64'hDEADBEEF);
      chk("sl_wb_reg_write", 64'(wb_reg_write), 64'd1);
      chk("sl_wb_rd", 64'(wb_rd), 64'd7);
      clear_inputs();

      // Vector store, zero-wait acks
      vec_op = 1; mem_write = 1; vreg_write = 1; vd = 3;
      rd2_v = 48'h1234_89ABCDEF; alu_result = 32'h40; dm_ack = 1;
      #1;
      chk("vs_b0_addr", 64'(dm_addr), 64'h40);
      chk("vs_b0_wdata", 64'(dm_wdata), 64'h89ABCDEF);
      chk("vs_b0_be", 64'(dm_be), 64'hF);
      chk("vs_b0_we", 64'(dm_we), 64'd1);
      chk("vs_b0_stall", 64'(stall), 64'd1);
      tick();
      chk("vs_b1_addr", 64'(dm_addr), 64'h44);
      chk("vs_b1_wdata", 64'(dm_wdata), 64'h00001234);
      chk("vs_b1_be", 64'(dm_be), 64'h3);
      chk("vs_b1_stall", 64'(stall), 64'd0);
      tick();
      chk("vs_wb_vreg_write", 64'(wb_vreg_write), 64'd0);
      clear_inputs();
      #1;
      chk("vs_done_req", 64'(dm_req), 64'd0);

      // Vector load
      vec_op = 1; mem_to_reg = 2'b01; vreg_write = 1; vd = 9;
      alu_result = 32'h80; dm_ack = 1; dm_rdata = 32'hCAFEF00D;
      #1;
      chk("vl_b0_stall", 64'(stall), 64'd1);
      tick();
      dm_rdata = 32'h77775A5A;
      #1;
      chk("vl_b1_addr", 64'(dm_addr), 64'h84);
      tick();
      chk("vl_wb_data_v", 64'(wb_data_v), 64'h5A5A_CAFEF00D);
      chk("vl_wb_vreg_write", 64'(wb_vreg_write), 64'd1);
      chk("vl_wb_vd", 64'(wb_vd), 64'd9);
      chk("vl_misalign", 64'(misalign), 64'd0);
      clear_inputs();

      // Misaligned scalar store
      mem_write = 1; alu_result = 32'h103; rd2 = 32'hA5A5A5A5; dm_ack = 1;
      #1;
      chk("ma_addr", 64'(dm_addr), 64'h100);
      chk("ma_wdata", 64'(dm_wdata), 64'hA5A5A5A5);
      tick();
      chk("ma_pulse", 64'(misalign), 64'd1);
      chk("ma_wb_reg_write", 64'(wb_reg_write), 64'd0);
      clear_inputs();
      tick();
      chk("ma_pulse_end", 64'(misalign), 64'd0);

      // Beat-1 address wraps
      vec_op = 1; mem_to_reg = 2'b01; vreg_write = 1; alu_result = 32'hFFFFFFFC;
      dm_ack = 1; dm_rdata = 32'h0BADF00D;
      tick();
      chk("wrap_b1_addr", 64'(dm_addr), 64'h0);
      tick();
      clear_inputs();

      // Reset during BEAT1
      vec_op = 1; mem_to_reg = 2'b01; vreg_write = 1; vd = 4; alu_result = 32'h200;
      dm_ack = 1; dm_rdata = 32'h11111111;
      tick();
      dm_ack = 0;
      #1;
      chk("rb_pre_req", 64'(dm_req), 64'd1);
      rst = 1'b1;
      #1;
      chk("rb_req", 64'(dm_req), 64'd0);
      chk("rb_stall", 64'(stall), 64'd0);
      chk("rb_wb_data", 64'(wb_data), 64'd0);
      chk("rb_wb_data_v", 64'(wb_data_v), 64'd0);
      chk("rb_wb_en", {62'd0, wb_reg_write, wb_vreg_write}, 64'd0);
      chk("rb_wb_dst", {54'd0, wb_rd, wb_vd}, 64'd0);
      clear_inputs();
      #1;
      rst = 1'b0;
      tick();
      #1;
      chk("rb_idle_req", 64'(dm_req), 64'd0);
      chk("rb_idle_vreg", 64'(wb_vreg_write), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- Consumer side of the EX/MEM pipeline register. Takes the frozen EX/MEM fields, performs scalar (32-bit) and vector (48-bit) loads/stores over a 32-bit data-memory req/ack interface, and produces the MEM/WB register contents.
- Stalls the upstream pipeline while a memory transaction is outstanding.
- Splits each 48-bit vector access into two memory beats.

Parameters:
- ADDR_W, 32, data-memory address width.
- VEC_W, 48, vector register width; fixed at 48, 2 beats.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- reg_write  in  1  scalar writeback enable from EX/MEM
- vreg_write  in  1  vector writeback enable from EX/MEM
- vec_op  in  1  memory op targets vector data
- mem_write  in  1  store
- mem_to_reg  in  2  00 alu_result, 01 memory load, 10 pc_count+4, 11 sign_imm
- pc_count  in  32  instruction PC
- alu_result  in  32  scalar result / memory address
- rd2  in  32  scalar store data
- sign_imm  in  32  immediate
- rd  in  5  scalar destination
- vd  in  5  vector destination
- alu_result_v  in  48  vector ALU result
- rd2_v  in  48  vector store data
- dm_req  out  1  memory request
- dm_we  out  1  write strobe
- dm_addr  out  ADDR_W  word-aligned address
- dm_wdata  out  32  write data
- dm_be  out  4  byte enables
- dm_rdata  in  32  read data, valid with dm_ack
- dm_ack  in  1  beat complete
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misalign  out  1  one-cycle pulse, address bits [1:0] nonzero
- wb_reg_write  out  1  MEM/WB scalar write enable
- wb_vreg_write  out  1  MEM/WB vector write enable
- wb_rd  out  5  MEM/WB scalar destination
- wb_vd  out  5  MEM/WB vector destination
- wb_data  out  32  MEM/WB scalar data
- wb_data_v  out  48  MEM/WB vector data

Behaviour:
Reset and op classification
- rst is asynchronous, active-high; clock is clk.
- Reset forces state IDLE and zeroes every registered output: wb_* = 0, misalign = 0, vector low-beat buffer = 0.
- dm_req and stall are combinational and go low with rst.
- Memory op: mem_write = 1, or mem_to_reg = 01. All-zero inputs (EX/MEM reset bubble) = no-op, which loads wb_reg_write = 0 and wb_vreg_write = 0.

Non-memory op (1-cycle latency, stall = 0)
- At posedge, the wb registers load rd, vd, reg_write and vreg_write.
- wb_data = alu_result, pc_count+4 or sign_imm, per mem_to_reg.
- wb_data_v = alu_result_v.

State IDLE (beat 0)
- For a memory op: dm_req = 1; dm_addr = {alu_result[31:2], 2'b00}; dm_we = mem_write.
- Scalar store: dm_wdata = rd2.
- Vector store: dm_wdata = rd2_v[31:0].
- dm_be = 4'b1111.
- No ack: stay IDLE, stall = 1. The MEM/WB load is a bubble (wb_reg_write = 0, wb_vreg_write = 0) every stalled cycle.
- Ack on a scalar op: stall = 0, wb loads.
  - Load: wb_data = dm_rdata.
  - Store: wb_reg_write = 0.
- Ack on a vector op: stall = 1, low buffer <= dm_rdata, go to BEAT1.

State BEAT1
- dm_req = 1; dm_addr = beat-0 address + 4.
- dm_wdata = {16'b0, rd2_v[47:32]}; dm_be = 4'b0011.
- No ack: stall = 1, bubble.
- Ack: stall = 0, go to IDLE, wb loads.
  - Load: wb_data_v = {dm_rdata[15:0], lowbuf}.
  - Store: wb_vreg_write = 0.

Other rules
- dm_addr, dm_we, dm_wdata and dm_be are held stable while dm_req = 1 and no ack.
- Zero-wait ack (ack in the first request cycle) is legal.
- dm_ack while dm_req = 0 is ignored.
- Misalign: the low address bits are dropped and the access proceeds. misalign pulses in the cycle after beat-0 completes.
- Beat-1 address wraps modulo 2^32.
- Reset mid-transaction: dm_req drops immediately, any partial vector data is discarded, and no writeback occurs.

Test Plan:
- Non-memory op: mem_to_reg = 10, pc_count = 0x100, rd = 5, reg_write = 1 -> next cycle wb_data = 0x104, wb_rd = 5, wb_reg_write = 1, stall never high.
- Scalar load, ack delayed 3 cycles: alu_result = 0x2000, dm_rdata = 0xDEADBEEF -> stall high 3 cycles with 3 bubbles, dm_addr = 0x2000 stable throughout, then wb_data = 0xDEADBEEF.
- Vector store, zero-wait ack: rd2_v = 0x1234_89ABCDEF, alu_result = 0x40.
  - Beat 0: addr 0x40, wdata 0x89ABCDEF, be 1111.
  - Beat 1: addr 0x44, wdata 0x00001234, be 0011.
  - Stall high exactly 1 cycle; wb_vreg_write = 0.
- Vector load: beat 0 returns 0xCAFEF00D, beat 1 returns 0xXXXX5A5A -> wb_data_v = 0x5A5A_CAFEF00D.
- Misaligned scalar store at 0x103 -> dm_addr = 0x100, misalign pulses 1 cycle.
- Boundary and reset: vector access at 0xFFFFFFFC -> beat-1 dm_addr = 0x00000000. Separately, assert rst during BEAT1 -> dm_req = 0 immediately, all wb outputs 0, state IDLE after release.
